// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction input side plus immediate output side.
// slave is the block's view; master is the surrounding decode/consumer view.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [2:0]        immsrc;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   imm;
   logic [TAG_W-1:0]  out_tag;
   logic              imm_err;

   modport slave (
      input  in_valid, instr, immsrc, in_tag, out_ready,
      output in_ready, out_valid, imm, out_tag, imm_err
   );

   modport master (
      output in_valid, instr, immsrc, in_tag, out_ready,
      input  in_ready, out_valid, imm, out_tag, imm_err
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: registered output stage plus one skid entry.
// Define IMM_OPCODE_DECODE_EN to derive the format from the opcode instead of immsrc.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   imm_gen_pipe_if.slave bus_if
);

   typedef enum logic [2:0] {
      FMT_I     = 3'b000,
      FMT_U     = 3'b001,
      FMT_S     = 3'b010,
      FMT_B     = 3'b011,
      FMT_J     = 3'b100,
      FMT_SHAMT = 3'b101,
      FMT_ZIMM  = 3'b110,
      FMT_ILL   = 3'b111
   } fmt_e;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   logic [31:0] ins;
   fmt_e        fmt;

   assign ins = bus_if.instr;

`ifdef IMM_OPCODE_DECODE_EN
   logic unused_immsrc;
   assign unused_immsrc = ^bus_if.immsrc;

   always_comb begin
      fmt = FMT_ILL;
      case (ins[6:0])
         7'b0000011, 7'b1100111: fmt = FMT_I;
         // OP-IMM funct3 001/101 are the shifts.
         7'b0010011:             fmt = (ins[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
         7'b0100011:             fmt = FMT_S;
         7'b1100011:             fmt = FMT_B;
         7'b1101111:             fmt = FMT_J;
         7'b0110111, 7'b0010111: fmt = FMT_U;
         7'b1110011:             fmt = ins[14] ? FMT_ZIMM : FMT_ILL;
         default:                fmt = FMT_ILL;
      endcase
   end
`else
   assign fmt = fmt_e'(bus_if.immsrc);
`endif

   logic [XLEN-1:0] imm_c;
   logic            err_c;

   // NOTE: every always_comb output gets a default first, otherwise unlisted cases infer latches.
   always_comb begin
      imm_c = '0;
      err_c = 1'b0;
      case (fmt)
         FMT_I:     imm_c = XLEN'($signed(ins[31:20]));
         FMT_U:     imm_c = XLEN'($signed({ins[31:12], 12'b0}));
         FMT_S:     imm_c = XLEN'($signed({ins[31:25], ins[11:7]}));
         FMT_B:     imm_c = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         FMT_J:     imm_c = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         FMT_SHAMT: imm_c = (XLEN == 32) ? XLEN'(ins[24:20]) : XLEN'(ins[25:20]);
         FMT_ZIMM:  imm_c = XLEN'(ins[19:15]);
         default:   err_c = 1'b1;
      endcase
   end

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q,   out_imm_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;
   logic             out_err_q,   out_err_d;
   logic             skid_full_q, skid_full_d;
   logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
   logic             skid_err_q,  skid_err_d;

   logic push, pop, out_load;

   assign push     = bus_if.in_valid & ~skid_full_q;
   assign pop      = out_valid_q & bus_if.out_ready;
   assign out_load = ~out_valid_q | pop;

   // The skid only fills while the output stage is full, so it always drains first on a pop.
   always_comb begin
      out_valid_d = out_valid_q;
      out_imm_d   = out_imm_q;
      out_tag_d   = out_tag_q;
      out_err_d   = out_err_q;
      skid_full_d = skid_full_q;
      skid_imm_d  = skid_imm_q;
      skid_tag_d  = skid_tag_q;
      skid_err_d  = skid_err_q;
      if (out_load) begin
         if (skid_full_q) begin
            out_valid_d = 1'b1;
            out_imm_d   = skid_imm_q;
            out_tag_d   = skid_tag_q;
            out_err_d   = skid_err_q;
            skid_full_d = 1'b0;
         end else begin
            out_valid_d = push;
            if (push) begin
               out_imm_d = imm_c;
               out_tag_d = bus_if.in_tag;
               out_err_d = err_c;
            end
         end
      end else if (push) begin
         skid_full_d = 1'b1;
         skid_imm_d  = imm_c;
         skid_tag_d  = bus_if.in_tag;
         skid_err_d  = err_c;
      end
   end

   // NOTE: data registers are reset too, so imm/out_tag/imm_err read as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_imm_q   <= '0;
         out_tag_q   <= '0;
         out_err_q   <= 1'b0;
         skid_full_q <= 1'b0;
         skid_imm_q  <= '0;
         skid_tag_q  <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         out_valid_q <= out_valid_d;
         out_imm_q   <= out_imm_d;
         out_tag_q   <= out_tag_d;
         out_err_q   <= out_err_d;
         skid_full_q <= skid_full_d;
         skid_imm_q  <= skid_imm_d;
         skid_tag_q  <= skid_tag_d;
         skid_err_q  <= skid_err_d;
      end
   end

   assign bus_if.in_ready  = ~skid_full_q;
   assign bus_if.out_valid = out_valid_q;
   assign bus_if.imm       = out_imm_q;
   assign bus_if.out_tag   = out_tag_q;
   assign bus_if.imm_err   = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance on a shared clock/reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_imm_gen_pipe;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64();

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef IMM_OPCODE_DECODE_EN
   localparam logic R_TYPE_ERR = 1'b1;
`else
   localparam logic R_TYPE_ERR = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive32(input logic v, input logic [31:0] i, input logic [2:0] s,
                          input logic [31:0] t);
      bus32.in_valid = v;
      bus32.instr    = i;
      bus32.immsrc   = s;
      bus32.in_tag   = t;
   endtask

   task automatic drive64(input logic v, input logic [31:0] i, input logic [2:0] s,
                          input logic [31:0] t);
      bus64.in_valid = v;
      bus64.instr    = i;
      bus64.immsrc   = s;
      bus64.in_tag   = t;
   endtask

   task automatic expect32(input string tag, input logic [31:0] imm, input logic err,
                           input logic [31:0] otag);
      check({tag, "_valid"}, bus32.out_valid, 1'b1);
      check({tag, "_imm"},   bus32.imm, imm);
      check({tag, "_err"},   bus32.imm_err, err);
      check({tag, "_tag"},   bus32.out_tag, otag);
   endtask

   logic [31:0] seq_instr [5];
   logic [2:0]  seq_src   [5];
   logic [31:0] seq_imm   [5];

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      drive32(1'b0, 32'h0, 3'd0, 32'h0);
      drive64(1'b0, 32'h0, 3'd0, 32'h0);
      bus32.out_ready = 1'b1;
      bus64.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_out_valid", bus32.out_valid, 1'b0);
      check("rst_imm",       bus32.imm, 32'h0);
      check("rst_out_tag",   bus32.out_tag, 32'h0);
      check("rst_imm_err",   bus32.imm_err, 1'b0);
      check("rst_out_valid64", bus64.out_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready",  bus32.in_ready, 1'b1);
      check("rel_out_valid", bus32.out_valid, 1'b0);

      // Reset release then back-to-back I/U/S/B/J, one result per cycle.
      seq_instr = '{32'hFFF00093, 32'h123450B7, 32'hFE20AC23, 32'hFE000EE3, 32'h0080006F};
      seq_src   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      seq_imm   = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000008};
      for (int k = 0; k < 5; k++) begin
         drive32(1'b1, seq_instr[k], seq_src[k], 32'h100 + k);
         @(negedge clk);
         expect32($sformatf("b2b%0d", k), seq_imm[k], 1'b0, 32'h100 + k);
         check($sformatf("b2b%0d_in_ready", k), bus32.in_ready, 1'b1);
      end
      drive32(1'b0, 32'h0, 3'd0, 32'h0);
      @(negedge clk);
      check("b2b_drained", bus32.out_valid, 1'b0);

      // Backpressure: A fills output, B fills skid, C is held off until space appears.
      bus32.out_ready = 1'b0;
      drive32(1'b1, 32'h00100093, 3'd0, 32'h200);
      @(negedge clk);
      expect32("bp_a", 32'h1, 1'b0, 32'h200);
      check("bp_a_in_ready", bus32.in_ready, 1'b1);
      drive32(1'b1, 32'h00200093, 3'd0, 32'h201);
      @(negedge clk);
      expect32("bp_full", 32'h1, 1'b0, 32'h200);
      check("bp_full_in_ready", bus32.in_ready, 1'b0);
      drive32(1'b1, 32'h7FF00093, 3'd0, 32'h202);
      @(negedge clk);
      expect32("bp_hold", 32'h1, 1'b0, 32'h200);
      check("bp_hold_in_ready", bus32.in_ready, 1'b0);
      bus32.out_ready = 1'b1;
      @(negedge clk);
      expect32("bp_b", 32'h2, 1'b0, 32'h201);
      check("bp_b_in_ready", bus32.in_ready, 1'b1);
      @(negedge clk);
      expect32("bp_c", 32'h7FF, 1'b0, 32'h202);
      drive32(1'b0, 32'h0, 3'd0, 32'h0);
      @(negedge clk);
      check("bp_drained", bus32.out_valid, 1'b0);

      // Illegal select, 32-bit shift amount, R-type word, U with bit 31 set.
      drive32(1'b1, 32'hFFFFFFFF, 3'd7, 32'h300);
      @(negedge clk);
      expect32("illegal", 32'h0, 1'b1, 32'h300);
      drive32(1'b1, 32'h00509093, 3'd5, 32'h301);
      @(negedge clk);
      expect32("slli32", 32'h5, 1'b0, 32'h301);
      drive32(1'b1, 32'h00000033, 3'd0, 32'h302);
      @(negedge clk);
      expect32("rtype", 32'h0, R_TYPE_ERR, 32'h302);
      drive32(1'b1, 32'h800000B7, 3'd1, 32'h303);
      @(negedge clk);
      expect32("u32_neg", 32'h80000000, 1'b0, 32'h303);
      drive32(1'b0, 32'h0, 3'd0, 32'h0);
      @(negedge clk);

      // Asynchronous reset with both entries occupied.
      bus32.out_ready = 1'b0;
      drive32(1'b1, 32'h00100093, 3'd0, 32'h400);
      @(negedge clk);
      drive32(1'b1, 32'h00200093, 3'd0, 32'h401);
      @(negedge clk);
      drive32(1'b0, 32'h0, 3'd0, 32'h0);
      check("mid_full_in_ready", bus32.in_ready, 1'b0);
      check("mid_full_valid",    bus32.out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid",    bus32.out_valid, 1'b0);
      check("mid_rst_imm",      bus32.imm, 32'h0);
      check("mid_rst_tag",      bus32.out_tag, 32'h0);
      check("mid_rst_in_ready", bus32.in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      bus32.out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", bus32.in_ready, 1'b1);
      check("post_rst_valid",    bus32.out_valid, 1'b0);
      @(negedge clk);
      check("post_rst_no_stale", bus32.out_valid, 1'b0);

      // XLEN=64 instance: sign-extended U, 6-bit shift amount, CSR zimm.
      drive64(1'b1, 32'h800000B7, 3'd1, 32'h500);
      @(negedge clk);
      check("x64_u_valid", bus64.out_valid, 1'b1);
      check("x64_u_imm",   bus64.imm, 64'hFFFFFFFF80000000);
      check("x64_u_tag",   bus64.out_tag, 32'h500);
      drive64(1'b1, 32'h03F09093, 3'd5, 32'h501);
      @(negedge clk);
      check("x64_shamt_imm", bus64.imm, 64'h3F);
      check("x64_shamt_err", bus64.imm_err, 1'b0);
      check("x64_shamt_tag", bus64.out_tag, 32'h501);
      drive64(1'b1, 32'h000FD073, 3'd6, 32'h502);
      @(negedge clk);
      check("x64_zimm_imm", bus64.imm, 64'h1F);
      check("x64_zimm_tag", bus64.out_tag, 32'h502);
      drive64(1'b1, 32'hFE000EE3, 3'd3, 32'h503);
      @(negedge clk);
      check("x64_b_imm", bus64.imm, 64'hFFFFFFFFFFFFFFFC);
      drive64(1'b0, 32'h0, 3'd0, 32'h0);
      @(negedge clk);
      check("x64_drained", bus64.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
